mem_access_stage: RTL and testbench

//  MEM stage directly downstream of the EX-stage ALU. Consumes ALU_result (address or result), store data, load/store

---
 rtl/mem_access_stage.sv | 156 +++++++++++++++
 tb/tb_mem_access_stage.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// MEM stage: issues req/gnt/rvalid data-memory transactions for EX loads/stores,
// stalls EX while busy, and emits one registered writeback beat per retired instruction.
module mem_access_stage #(
    parameter int XLEN    = 64,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [XLEN-1:0] ex_alu_result,
    input  logic [XLEN-1:0] ex_store_data,
    input  logic            ex_is_load,
    input  logic            ex_is_store,
    input  logic            ex_byte_op,
    input  logic [4:0]      ex_rd,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [7:0]      mem_wstrb,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            misaligned,
    output logic            bus_err,
    output logic [1:0]      state_dbg
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] REQ    = 2'd1;
    localparam logic [1:0] WAIT_R = 2'd2;

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    // Handshake: an EX instruction transfers on a cycle where ex_valid & ex_ready;
    // a memory request transfers on mem_req & mem_gnt; read data is taken on mem_rvalid in REQ/WAIT_R.
    logic [1:0]      state;
    logic [CW-1:0]   tmo_cnt;
    logic [4:0]      rd_q;
    logic [2:0]      off_q;
    logic            byte_q;
    logic            load_q;
    logic            xfer;
    logic            is_mem;
    logic            timed_out;
    logic [7:0]      rbyte;
    logic [XLEN-1:0] load_data;

    assign ex_ready  = (state == IDLE);
    assign state_dbg = state;
    assign xfer      = ex_valid & ex_ready;
    assign is_mem    = ex_is_load | ex_is_store;
    assign timed_out = (tmo_cnt == TMO_LAST);
    assign rbyte     = mem_rdata[{off_q, 3'b000} +: 8];
    assign load_data = byte_q ? {{(XLEN-8){rbyte[7]}}, rbyte} : mem_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            tmo_cnt    <= '0;
            rd_q       <= '0;
            off_q      <= '0;
            byte_q     <= 1'b0;
            load_q     <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
            wb_valid   <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= '0;
            misaligned <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            wb_valid   <= 1'b0;
            misaligned <= 1'b0;
            bus_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (xfer) begin
                        if (!is_mem) begin
                            wb_valid <= 1'b1;
                            wb_data  <= ex_alu_result;
                            wb_rd    <= ex_rd;
                        end else if (!ex_byte_op && ex_alu_result[2:0] != 3'b000) begin
                            misaligned <= 1'b1;
                        end else begin
                            // A load flag wins when both load and store are set.
                            rd_q     <= ex_rd;
                            off_q    <= ex_alu_result[2:0];
                            byte_q   <= ex_byte_op;
                            load_q   <= ex_is_load;
                            tmo_cnt  <= '0;
                            state    <= REQ;
                            mem_req  <= 1'b1;
                            mem_we   <= ~ex_is_load;
                            mem_addr <= {ex_alu_result[XLEN-1:3], 3'b000};
                            if (ex_byte_op) begin
                                mem_wstrb <= 8'b1 << ex_alu_result[2:0];
                                mem_wdata <= {(XLEN/8){ex_store_data[7:0]}};
                            end else begin
                                mem_wstrb <= 8'hFF;
                                mem_wdata <= ex_store_data;
                            end
                        end
                    end
                end
                REQ: begin
                    if (mem_gnt && (!load_q || mem_rvalid)) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        state   <= IDLE;
                        if (load_q) begin
                            wb_valid <= 1'b1;
                            wb_rd    <= rd_q;
                            wb_data  <= load_data;
                        end
                    end else if (timed_out) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        bus_err <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + CW'(1);
                        if (mem_gnt) begin
                            mem_req <= 1'b0;
                            mem_we  <= 1'b0;
                            state   <= WAIT_R;
                        end
                    end
                end
                WAIT_R: begin
                    if (mem_rvalid) begin
                        wb_valid <= 1'b1;
                        wb_rd    <= rd_q;
                        wb_data  <= load_data;
                        state    <= IDLE;
                    end else if (timed_out) begin
                        bus_err <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: writeback beats are checked against a queue
// of expected {rd, data} values pushed when each instruction is driven.
module tb_mem_access_stage;

    localparam int XLEN = 64;
    localparam int WB_W = 5 + XLEN;

    logic            clk;
    logic            rst;
    logic            ex_valid;
    logic            ex_ready;
    logic [XLEN-1:0] ex_alu_result;
    logic [XLEN-1:0] ex_store_data;
    logic            ex_is_load;
    logic            ex_is_store;
    logic            ex_byte_op;
    logic [4:0]      ex_rd;
    logic            mem_req;
    logic            mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [7:0]      mem_wstrb;
    logic            mem_gnt;
    logic            mem_rvalid;
    logic [XLEN-1:0] mem_rdata;
    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            misaligned;
    logic            bus_err;
    logic [1:0]      state_dbg;

    int n_checks = 0;
    int n_fail   = 0;
    logic [WB_W-1:0] exp_q[$];

    mem_access_stage #(.XLEN(XLEN), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
        .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
        .ex_byte_op(ex_byte_op), .ex_rd(ex_rd),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .misaligned(misaligned), .bus_err(bus_err), .state_dbg(state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [63:0] alu, input logic [63:0] sdata, input logic ld,
                         input logic st, input logic bop, input logic [4:0] rd);
        ex_valid      = 1'b1;
        ex_alu_result = alu;
        ex_store_data = sdata;
        ex_is_load    = ld;
        ex_is_store   = st;
        ex_byte_op    = bop;
        ex_rd         = rd;
    endtask

    // Scoreboard: every writeback beat must match the oldest expected entry.
    always @(negedge clk) begin
        if (rst === 1'b0 && wb_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("wb_unexpected", 64'(wb_valid), 64'd0);
            end else begin
                logic [WB_W-1:0] e;
                e = exp_q.pop_front();
                check("wb_rd", 64'(wb_rd), 64'(e[WB_W-1:XLEN]));
                check("wb_data", wb_data, e[XLEN-1:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        logic [63:0] r;
        logic [4:0]  rr;
        rst = 1'b1; ex_valid = 1'b0; ex_alu_result = '0; ex_store_data = '0;
        ex_is_load = 1'b0; ex_is_store = 1'b0; ex_byte_op = 1'b0; ex_rd = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        step(); step();
        check("rst_mem_req", 64'(mem_req), 64'd0);
        check("rst_wb_valid", 64'(wb_valid), 64'd0);
        check("rst_ex_ready", 64'(ex_ready), 64'd1);
        check("rst_mem_addr", mem_addr, 64'd0);
        check("rst_wb_data", wb_data, 64'd0);
        check("rst_bus_err", 64'(bus_err), 64'd0);
        rst = 1'b0;
        step();

        // 1: ALU op, one-cycle latency, no stall
        drive(64'h1234, 64'd0, 1'b0, 1'b0, 1'b0, 5'd5);
        exp_q.push_back({5'd5, 64'h1234});
        step();
        ex_valid = 1'b0;
        check("alu_wb_valid", 64'(wb_valid), 64'd1);
        check("alu_ex_ready", 64'(ex_ready), 64'd1);
        check("alu_mem_req", 64'(mem_req), 64'd0);

        // back-to-back random ALU ops
        for (int i = 0; i < 4; i++) begin
            r  = {$urandom, $urandom};
            rr = 5'($urandom_range(0, 31));
            drive(r, 64'd0, 1'b0, 1'b0, 1'b0, rr);
            exp_q.push_back({rr, r});
            step();
            check("alu_b2b_ready", 64'(ex_ready), 64'd1);
        end
        ex_valid = 1'b0;
        step();

        // 2: LB 0x1003, gnt immediately, rvalid two cycles later
        drive(64'h1003, 64'd0, 1'b1, 1'b0, 1'b1, 5'd7);
        exp_q.push_back({5'd7, 64'hFFFF_FFFF_FFFF_FF80});
        step();
        ex_valid = 1'b0;
        check("lb_mem_req", 64'(mem_req), 64'd1);
        check("lb_mem_addr", mem_addr, 64'h1000);
        check("lb_mem_we", 64'(mem_we), 64'd0);
        check("lb_ready_c1", 64'(ex_ready), 64'd0);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        check("lb_req_drop", 64'(mem_req), 64'd0);
        check("lb_ready_c2", 64'(ex_ready), 64'd0);
        step();
        check("lb_ready_c3", 64'(ex_ready), 64'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 64'h0123_4567_8044_5566;
        step();
        mem_rvalid = 1'b0;
        check("lb_wb_valid", 64'(wb_valid), 64'd1);
        check("lb_ready_back", 64'(ex_ready), 64'd1);

        // 3: SB 0x2005 with grant delayed four cycles
        drive(64'h2005, 64'hAB, 1'b0, 1'b1, 1'b1, 5'd9);
        step();
        ex_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("sb_req", 64'(mem_req), 64'd1);
            check("sb_we", 64'(mem_we), 64'd1);
            check("sb_wstrb", 64'(mem_wstrb), 64'h20);
            check("sb_wdata", mem_wdata, 64'hABAB_ABAB_ABAB_ABAB);
            check("sb_addr", mem_addr, 64'h2000);
            check("sb_no_wb", 64'(wb_valid), 64'd0);
            if (i == 4) mem_gnt = 1'b1;
            step();
        end
        mem_gnt = 1'b0;
        check("sb_done_req", 64'(mem_req), 64'd0);
        check("sb_done_ready", 64'(ex_ready), 64'd1);
        check("sb_done_no_wb", 64'(wb_valid), 64'd0);

        // SD full-width strobe and data
        drive(64'h2808, 64'hDEAD_BEEF_0BAD_F00D, 1'b0, 1'b1, 1'b0, 5'd1);
        step();
        ex_valid = 1'b0;
        check("sd_wstrb", 64'(mem_wstrb), 64'hFF);
        check("sd_wdata", mem_wdata, 64'hDEAD_BEEF_0BAD_F00D);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;

        // 4: misaligned LD
        drive(64'h3004, 64'd0, 1'b1, 1'b0, 1'b0, 5'd3);
        step();
        ex_valid = 1'b0;
        check("mis_pulse", 64'(misaligned), 64'd1);
        check("mis_no_req", 64'(mem_req), 64'd0);
        check("mis_ready", 64'(ex_ready), 64'd1);
        step();
        check("mis_pulse_end", 64'(misaligned), 64'd0);
        check("mis_still_no_req", 64'(mem_req), 64'd0);

        // 5: LD with grant but no read data -> bus error after 16 busy cycles
        drive(64'h4000, 64'd0, 1'b1, 1'b0, 1'b0, 5'd4);
        step();
        ex_valid = 1'b0;
        mem_gnt  = 1'b1;
        step();
        mem_gnt = 1'b0;
        cyc = 1;
        while (bus_err !== 1'b1 && cyc < 40) begin
            step();
            cyc++;
        end
        check("tmo_latency", 64'(cyc), 64'd16);
        check("tmo_ready", 64'(ex_ready), 64'd1);
        check("tmo_req", 64'(mem_req), 64'd0);
        step();
        check("tmo_pulse_end", 64'(bus_err), 64'd0);

        // LD+ST flags together act as a load; gnt and rvalid together complete at once
        drive(64'h5008, 64'h55, 1'b1, 1'b1, 1'b0, 5'd10);
        exp_q.push_back({5'd10, 64'hCAFE_0000_1111_2222});
        step();
        ex_valid = 1'b0;
        check("ldst_we", 64'(mem_we), 64'd0);
        mem_gnt    = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 64'hCAFE_0000_1111_2222;
        step();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        check("fast_wb_valid", 64'(wb_valid), 64'd1);
        check("fast_ready", 64'(ex_ready), 64'd1);

        // 6: reset while in WAIT_R, then a stray rvalid
        drive(64'h6000, 64'd0, 1'b1, 1'b0, 1'b0, 5'd6);
        step();
        ex_valid = 1'b0;
        mem_gnt  = 1'b1;
        step();
        mem_gnt = 1'b0;
        check("rst6_wait_state", 64'(state_dbg), 64'd2);
        #2 rst = 1'b1;
        #1;
        check("rst6_ready", 64'(ex_ready), 64'd1);
        check("rst6_state", 64'(state_dbg), 64'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 64'hFFFF_0000_FFFF_0000;
        step();
        rst = 1'b0;
        step();
        mem_rvalid = 1'b0;
        check("rst6_no_wb", 64'(wb_valid), 64'd0);
        check("rst6_no_err", 64'(bus_err), 64'd0);
        check("rst6_idle", 64'(state_dbg), 64'd0);

        // reset while a request is outstanding drops mem_req without a clock edge
        drive(64'h7000, 64'd0, 1'b1, 1'b0, 1'b0, 5'd2);
        step();
        ex_valid = 1'b0;
        check("rst_req_before", 64'(mem_req), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_req_async", 64'(mem_req), 64'd0);
        step();
        rst = 1'b0;
        step(); step();

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
